// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache: 16 one-word frames, single outstanding miss.
// Hits return data combinationally in IDLE; misses go through a FETCH state until memory drops iwait.
module icache_dm (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic        dbg_state_o
);

    // Handshake: in FETCH, iREN=1 and iaddr hold steady; the word on iload is
    // taken at the first rising edge where iwait=0, which also ends the fill.

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    localparam int FRAMES = 16;

    state_e      state_q, state_d;
    logic [29:0] miss_addr_q, miss_addr_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    logic [FRAMES-1:0] valid_q;
    logic [25:0]       tag_q  [FRAMES];
    logic [31:0]       data_q [FRAMES];

    logic [25:0] req_tag;
    logic [3:0]  req_idx;
    logic [3:0]  fill_idx;
    logic [25:0] fill_tag;
    logic        lookup_hit;
    logic        fill_en;
    logic        unused_offset;

    assign req_tag       = imemaddr[31:6];
    assign req_idx       = imemaddr[5:2];
    assign unused_offset = ^imemaddr[1:0];
    assign fill_tag      = miss_addr_q[29:4];
    assign fill_idx      = miss_addr_q[3:0];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        fill_en      = 1'b0;
        ihit         = 1'b0;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit        = 1'b1;
                        hit_count_d = hit_count_q + 32'd1;
                    end else begin
                        miss_addr_d  = imemaddr[31:2];
                        miss_count_d = miss_count_q + 32'd1;
                        state_d      = FETCH;
                    end
                end
            end
            FETCH: begin
                // The latched miss is always completed, even if the request moved away.
                iREN  = 1'b1;
                iaddr = {miss_addr_q, 2'b00};
                if (!iwait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imemload    = ihit ? data_q[req_idx] : 32'h0;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= 30'h0;
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset: they are never observed while the valid bit is clear.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule
